// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcode/Funct
// constants, datapath mux encodings and exception cause codes.
package ctrl_pkg;

    typedef enum logic [5:0] {
        S_RESET = 6'd0, S_FETCH, S_FETCH_WB, S_DECODE, S_EXEC_R, S_R_WB,
        S_BRANCH, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_LUI_WB,
        S_JUMP, S_BREAK, S_EXC_EPC, S_EXC_JUMP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_NOP   = 6'h00;
    localparam logic [5:0] FN_BREAK = 6'h0D;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_XOR   = 6'h26;

    typedef enum logic [2:0] {
        ALU_LOAD, ALU_ADD, ALU_SUB, ALU_AND, ALU_INC, ALU_NOT, ALU_XOR, ALU_CMP
    } aluop_e;

    localparam logic [1:0] SRCB_4      = 2'b00;
    localparam logic [1:0] SRCB_B      = 2'b01;
    localparam logic [1:0] SRCB_SHL2   = 2'b10;
    localparam logic [1:0] SRCB_SE     = 2'b11;

    localparam logic [1:0] PCS_ALU     = 2'b00;
    localparam logic [1:0] PCS_ALUOUT  = 2'b01;
    localparam logic [1:0] PCS_JUMP    = 2'b10;
    localparam logic [1:0] PCS_EXC     = 2'b11;

    localparam logic [1:0] MTR_ALUOUT  = 2'b00;
    localparam logic [1:0] MTR_MDR     = 2'b01;
    localparam logic [1:0] MTR_LUI     = 2'b10;

    localparam logic CAUSE_UNDEF = 1'b0;
    localparam logic CAUSE_OVF   = 1'b1;

    function automatic logic [2:0] funct_aluop(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_XOR:  return ALU_XOR;
            default: return ALU_LOAD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Memory wait counter shared by FETCH, MEM_RD and MEM_WR; done flags the
// last cycle of a MEM_WAIT-long access.
module ctrl_wait_cnt #(
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 3
) (
    input  logic clk,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic done_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_WAIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/mc_control_unit.sv
// Moore control FSM for the multicycle MIPS-subset datapath with precise
// exceptions. Define CTRL_OVF_EXC_EN to trap ADD/SUB overflow as cause 1.
module mc_control_unit
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [5:0] OP,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       Overflow,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic       AWrite,
    output logic       BWrite,
    output logic       ALUOutWrite,
    output logic       EPCWrite,
    output logic       CauseWrite,
    output logic       IntCause,
    output logic [1:0] ALUSrcB,
    output logic [1:0] MemtoReg,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic [5:0] State,
    output logic       Halted
);

    state_e state_q, state_d;
    logic   cause_q, cause_d;
    logic   wait_done;

`ifndef CTRL_OVF_EXC_EN
    logic unused_ovf;
    assign unused_ovf = Overflow;
`endif

    // Counter restarts on every state change so each wait state enters at 0.
    ctrl_wait_cnt #(.MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)) u_wait (
        .clk     (clk),
        .rst_i   (Reset),
        .clear_i (state_d != state_q),
        .en_i    (state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR}),
        .done_o  (wait_done)
    );

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        AWrite      = 1'b0;
        BWrite      = 1'b0;
        ALUOutWrite = 1'b0;
        EPCWrite    = 1'b0;
        CauseWrite  = 1'b0;
        IntCause    = 1'b0;
        ALUSrcB     = SRCB_4;
        MemtoReg    = MTR_ALUOUT;
        PCSource    = PCS_ALU;
        ALUOp       = ALU_LOAD;
        Halted      = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                if (wait_done) state_d = S_FETCH_WB;
            end
            S_FETCH_WB: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUOp   = ALU_ADD;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                AWrite      = 1'b1;
                BWrite      = 1'b1;
                ALUOutWrite = 1'b1;
                ALUSrcB     = SRCB_SHL2;
                ALUOp       = ALU_ADD;
                state_d     = S_EXC_EPC;
                cause_d     = CAUSE_UNDEF;
                case (OP)
                    OP_RTYPE: begin
                        case (Funct)
                            FN_NOP:   state_d = S_FETCH;
                            FN_BREAK: state_d = S_BREAK;
                            FN_ADD, FN_SUB, FN_AND, FN_XOR: state_d = S_EXEC_R;
                            default:  state_d = S_EXC_EPC;
                        endcase
                    end
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_LUI:         state_d = S_LUI_WB;
                    OP_J:           state_d = S_JUMP;
                    default:        state_d = S_EXC_EPC;
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_B;
                ALUOutWrite = 1'b1;
                ALUOp       = funct_aluop(Funct);
                state_d     = S_R_WB;
`ifdef CTRL_OVF_EXC_EN
                if (Overflow && (Funct == FN_ADD || Funct == FN_SUB)) begin
                    state_d = S_EXC_EPC;
                    cause_d = CAUSE_OVF;
                end
`endif
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_B;
                ALUOp    = ALU_SUB;
                PCSource = PCS_ALUOUT;
                PCWrite  = (OP == OP_BEQ) ? Zero : ~Zero;
                state_d  = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_SE;
                ALUOp       = ALU_ADD;
                ALUOutWrite = 1'b1;
                state_d     = (OP == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (wait_done) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = MTR_MDR;
                state_d  = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (wait_done) state_d = S_FETCH;
            end
            S_LUI_WB: begin
                RegWrite = 1'b1;
                MemtoReg = MTR_LUI;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCS_JUMP;
                state_d  = S_FETCH;
            end
            S_BREAK: Halted = 1'b1;
            S_EXC_EPC: begin
                ALUOp      = ALU_SUB;
                EPCWrite   = 1'b1;
                CauseWrite = 1'b1;
                IntCause   = cause_q;
                state_d    = S_EXC_JUMP;
            end
            S_EXC_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCS_EXC;
                state_d  = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase

        // Reset kills any in-flight write immediately, before the edge lands.
        if (Reset) begin
            PCWrite     = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            AWrite      = 1'b0;
            BWrite      = 1'b0;
            ALUOutWrite = 1'b0;
            EPCWrite    = 1'b0;
            CauseWrite  = 1'b0;
            Halted      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_RESET;
            cause_q <= CAUSE_UNDEF;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: two instances (MEM_WAIT 1 and 3)
// share stimulus; per-cycle expectations are queued and checked at negedge.
module tb_mc_control_unit;

    localparam logic [5:0] RST = 6'd0, FET = 6'd1, FWB = 6'd2, DEC = 6'd3,
                           EXR = 6'd4, RWB = 6'd5, BRA = 6'd6, MAD = 6'd7,
                           MRD = 6'd8, MWB = 6'd9, MWR = 6'd10, LUI = 6'd11,
                           JMP = 6'd12, BRK = 6'd13, EEPC = 6'd14, EJMP = 6'd15;

    localparam logic [10:0] E_PCW = 11'h400, E_MRD = 11'h200, E_MWR = 11'h100,
                            E_IRW = 11'h080, E_RGW = 11'h040, E_AW  = 11'h020,
                            E_BW  = 11'h010, E_AOW = 11'h008, E_EPC = 11'h004,
                            E_CAW = 11'h002, E_HLT = 11'h001;

    typedef struct {
        logic [5:0]  st;
        logic [10:0] en;
        logic [12:0] sm;
        logic [12:0] sv;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    logic [5:0] OP = 6'h00, Funct = 6'h00;
    logic Zero = 1'b0, Overflow = 1'b0;

    logic [1:0] pcw, iord, mrd, mwr, irw, rgw, rdst, srca, aw, bw, aow, epcw, caw, ic, hlt;
    logic [1:0][1:0]  srcb, mtr, pcs;
    logic [1:0][2:0]  aluop;
    logic [1:0][5:0]  st;
    logic [1:0][10:0] en_o;
    logic [1:0][12:0] sl_o;

    exp_t q[$];
    exp_t mx;
    bit   mon_en = 1'b0;
    int   mon_d = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mc_control_unit #(.MEM_WAIT(g == 0 ? 1 : 3), .CNT_W(3)) dut (
            .clk(clk), .Reset(Reset), .OP(OP), .Funct(Funct), .Zero(Zero),
            .Overflow(Overflow), .PCWrite(pcw[g]), .IorD(iord[g]),
            .MemRead(mrd[g]), .MemWrite(mwr[g]), .IRWrite(irw[g]),
            .RegWrite(rgw[g]), .RegDst(rdst[g]), .ALUSrcA(srca[g]),
            .AWrite(aw[g]), .BWrite(bw[g]), .ALUOutWrite(aow[g]),
            .EPCWrite(epcw[g]), .CauseWrite(caw[g]), .IntCause(ic[g]),
            .ALUSrcB(srcb[g]), .MemtoReg(mtr[g]), .PCSource(pcs[g]),
            .ALUOp(aluop[g]), .State(st[g]), .Halted(hlt[g])
        );
        assign en_o[g] = {pcw[g], mrd[g], mwr[g], irw[g], rgw[g], aw[g], bw[g],
                          aow[g], epcw[g], caw[g], hlt[g]};
        assign sl_o[g] = {iord[g], rdst[g], srca[g], ic[g], srcb[g], mtr[g],
                          pcs[g], aluop[g]};
    end

    // Scoreboard: one expected entry per cycle, popped at each negedge.
    always @(negedge clk) begin
        if (mon_en && q.size() > 0) begin
            mx = q.pop_front();
            n_chk++;
            if (st[mon_d] !== mx.st) begin
                n_fail++;
                $display("FAIL %s state: got %0d expected %0d", mx.tag, st[mon_d], mx.st);
            end
            n_chk++;
            if (en_o[mon_d] !== mx.en) begin
                n_fail++;
                $display("FAIL %s enables: got %h expected %h", mx.tag, en_o[mon_d], mx.en);
            end
            if (mx.sm != '0) begin
                n_chk++;
                if ((sl_o[mon_d] & mx.sm) !== mx.sv) begin
                    n_fail++;
                    $display("FAIL %s selects: got %h expected %h (mask %h)",
                             mx.tag, sl_o[mon_d] & mx.sm, mx.sv, mx.sm);
                end
            end
        end
    end

    // -1 marks a select as don't-care for that cycle.
    task automatic push(input logic [5:0] s, input logic [10:0] e, input int iord_v,
                        input int rdst_v, input int srca_v, input int ic_v, input int srcb_v,
                        input int mtr_v, input int pcs_v, input int alu_v, input string tag);
        exp_t x;
        x.st = s; x.en = e; x.sm = '0; x.sv = '0; x.tag = tag;
        if (iord_v >= 0) begin x.sm[12] = 1'b1; x.sv[12] = iord_v[0]; end
        if (rdst_v >= 0) begin x.sm[11] = 1'b1; x.sv[11] = rdst_v[0]; end
        if (srca_v >= 0) begin x.sm[10] = 1'b1; x.sv[10] = srca_v[0]; end
        if (ic_v   >= 0) begin x.sm[9]  = 1'b1; x.sv[9]  = ic_v[0];   end
        if (srcb_v >= 0) begin x.sm[8:7] = 2'b11;  x.sv[8:7] = srcb_v[1:0]; end
        if (mtr_v  >= 0) begin x.sm[6:5] = 2'b11;  x.sv[6:5] = mtr_v[1:0];  end
        if (pcs_v  >= 0) begin x.sm[4:3] = 2'b11;  x.sv[4:3] = pcs_v[1:0];  end
        if (alu_v  >= 0) begin x.sm[2:0] = 3'b111; x.sv[2:0] = alu_v[2:0];  end
        q.push_back(x);
    endtask

    task automatic push_front(input int w);
        for (int i = 0; i < w; i++) push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "fetch");
        push(FWB, E_IRW | E_PCW, -1, -1, 0, -1, 0, -1, 0, 1, "fetch_wb");
        push(DEC, E_AW | E_BW | E_AOW, -1, -1, 0, -1, 2, -1, -1, 1, "decode");
    endtask

    task automatic start(input int d, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic ov);
        mon_en = 1'b0; Reset = 1'b1; OP = op; Funct = fn; Zero = z; Overflow = ov;
        @(posedge clk); #1;
        n_chk++;
        if (st[d] !== RST) begin
            n_fail++; $display("FAIL reset state: got %0d expected 0", st[d]);
        end
        n_chk++;
        if (en_o[d] !== '0) begin
            n_fail++; $display("FAIL reset enables: got %h expected 0", en_o[d]);
        end
        Reset = 1'b0; mon_d = d;
        push(RST, '0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_cycle");
    endtask

    task automatic drain(input string tag);
        int n = 0;
        mon_en = 1'b1;
        while (q.size() > 0 && n < 64) begin @(posedge clk); n++; end
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s drain: %0d entries left, expected 0", tag, q.size());
            q.delete();
        end
        mon_en = 1'b0;
    endtask

    task automatic test_reset;
        start(0, 6'h00, 6'h00, 1'b0, 1'b0);
        push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "first_fetch");
        drain("reset");
    endtask

    task automatic test_add;
        start(0, 6'h00, 6'h20, 1'b0, 1'b0);
        push_front(1);
        push(EXR, E_AOW, -1, -1, 1, -1, 1, -1, -1, 1, "add_exec");
        push(RWB, E_RGW, -1, 1, -1, -1, -1, 0, -1, -1, "add_wb");
        push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "add_refetch");
        drain("add");
    endtask

    task automatic test_alu_funct;
        logic [5:0] fn[3]  = '{6'h22, 6'h24, 6'h26};
        int         alu[3] = '{2, 3, 6};
        logic       ov[3]  = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            start(0, 6'h00, fn[i], 1'b0, ov[i]);
            push_front(1);
            push(EXR, E_AOW, -1, -1, 1, -1, 1, -1, -1, alu[i], "rtype_exec");
            push(RWB, E_RGW, -1, 1, -1, -1, -1, 0, -1, -1, "rtype_wb");
            push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "rtype_refetch");
            drain("rtype");
        end
    endtask

    task automatic test_lw_wait3;
        start(1, 6'h23, 6'h00, 1'b0, 1'b0);
        push_front(3);
        push(MAD, E_AOW, -1, -1, 1, -1, 3, -1, -1, 1, "lw_addr");
        for (int i = 0; i < 3; i++) push(MRD, E_MRD, 1, -1, -1, -1, -1, -1, -1, -1, "lw_rd");
        push(MWB, E_RGW, -1, 0, -1, -1, -1, 1, -1, -1, "lw_wb");
        push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "lw_refetch");
        drain("lw");
    endtask

    task automatic test_sw;
        start(0, 6'h2B, 6'h00, 1'b0, 1'b0);
        push_front(1);
        push(MAD, E_AOW, -1, -1, 1, -1, 3, -1, -1, 1, "sw_addr");
        push(MWR, E_MWR, 1, -1, -1, -1, -1, -1, -1, -1, "sw_wr");
        push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "sw_refetch");
        drain("sw");
    endtask

    task automatic test_branch;
        logic [5:0] op[4]  = '{6'h05, 6'h05, 6'h04, 6'h04};
        logic       z[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       tk[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            start(0, op[i], 6'h00, z[i], 1'b0);
            push_front(1);
            push(BRA, tk[i] ? E_PCW : 11'h000, -1, -1, 1, -1, 1, -1, 1, 2, "branch");
            push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "branch_refetch");
            drain("branch");
        end
    endtask

    task automatic test_lui_jump_nop;
        start(0, 6'h0F, 6'h00, 1'b0, 1'b0);
        push_front(1);
        push(LUI, E_RGW, -1, 0, -1, -1, -1, 2, -1, -1, "lui_wb");
        push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "lui_refetch");
        drain("lui");
        start(0, 6'h02, 6'h00, 1'b0, 1'b0);
        push_front(1);
        push(JMP, E_PCW, -1, -1, -1, -1, -1, -1, 2, -1, "jump");
        push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "jump_refetch");
        drain("jump");
        start(0, 6'h00, 6'h00, 1'b0, 1'b0);
        push_front(1);
        push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "nop_refetch");
        drain("nop");
    endtask

    task automatic test_undefined;
        logic [5:0] op[2] = '{6'h3F, 6'h00};
        logic [5:0] fn[2] = '{6'h00, 6'h3F};
        for (int i = 0; i < 2; i++) begin
            start(0, op[i], fn[i], 1'b0, 1'b0);
            push_front(1);
            push(EEPC, E_EPC | E_CAW, -1, -1, 0, 0, 0, -1, -1, 2, "undef_epc");
            push(EJMP, E_PCW, -1, -1, -1, -1, -1, -1, 3, -1, "undef_jump");
            push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "undef_refetch");
            drain("undef");
        end
    endtask

    task automatic test_overflow;
        start(0, 6'h00, 6'h22, 1'b0, 1'b1);
        push_front(1);
        push(EXR, E_AOW, -1, -1, 1, -1, 1, -1, -1, 2, "ovf_exec");
`ifdef CTRL_OVF_EXC_EN
        push(EEPC, E_EPC | E_CAW, -1, -1, 0, 1, 0, -1, -1, 2, "ovf_epc");
        push(EJMP, E_PCW, -1, -1, -1, -1, -1, -1, 3, -1, "ovf_jump");
        push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "ovf_refetch");
        drain("ovf");
        // Next instruction is undefined: cause must come back as 0.
        OP = 6'h3F; Funct = 6'h00; Overflow = 1'b0;
        push(FWB, E_IRW | E_PCW, -1, -1, 0, -1, 0, -1, 0, 1, "fetch_wb");
        push(DEC, E_AW | E_BW | E_AOW, -1, -1, 0, -1, 2, -1, -1, 1, "decode");
        push(EEPC, E_EPC | E_CAW, -1, -1, 0, 0, 0, -1, -1, 2, "after_ovf_epc");
        push(EJMP, E_PCW, -1, -1, -1, -1, -1, -1, 3, -1, "after_ovf_jump");
        drain("after_ovf");
`else
        push(RWB, E_RGW, -1, 1, -1, -1, -1, 0, -1, -1, "ovf_wrapped_wb");
        push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "ovf_refetch");
        drain("ovf");
`endif
    endtask

    task automatic test_break;
        start(0, 6'h00, 6'h0D, 1'b0, 1'b0);
        push_front(1);
        for (int i = 0; i < 5; i++) push(BRK, E_HLT, -1, -1, -1, -1, -1, -1, -1, -1, "break_hold");
        drain("break");
        #1;
        n_chk++;
        if (hlt[0] !== 1'b1 || st[0] !== BRK) begin
            n_fail++; $display("FAIL break_still_halted: got halt=%b state=%0d expected 1/13", hlt[0], st[0]);
        end
        Reset = 1'b1; #1;
        n_chk++;
        if (hlt[0] !== 1'b0) begin
            n_fail++; $display("FAIL break_reset_halt: got %b expected 0", hlt[0]);
        end
        @(posedge clk); #1;
        n_chk++;
        if (st[0] !== RST) begin
            n_fail++; $display("FAIL break_reset_state: got %0d expected 0", st[0]);
        end
        Reset = 1'b0;
    endtask

    task automatic test_reset_mid_memwr;
        start(1, 6'h2B, 6'h00, 1'b0, 1'b0);
        push_front(3);
        push(MAD, E_AOW, -1, -1, 1, -1, 3, -1, -1, 1, "sw3_addr");
        push(MWR, E_MWR, 1, -1, -1, -1, -1, -1, -1, -1, "sw3_wr");
        drain("sw3");
        #1;
        n_chk++;
        if (mwr[1] !== 1'b1 || st[1] !== MWR) begin
            n_fail++; $display("FAIL memwr_active: got mw=%b state=%0d expected 1/10", mwr[1], st[1]);
        end
        Reset = 1'b1; #1;
        n_chk++;
        if (mwr[1] !== 1'b0) begin
            n_fail++; $display("FAIL memwr_reset_drop: got %b expected 0", mwr[1]);
        end
        @(posedge clk); #1;
        n_chk++;
        if (st[1] !== RST) begin
            n_fail++; $display("FAIL memwr_reset_state: got %0d expected 0", st[1]);
        end
        Reset = 1'b0;
    endtask

    task automatic test_back_to_back;
        start(1, 6'h00, 6'h20, 1'b0, 1'b0);
        push_front(3);
        push(EXR, E_AOW, -1, -1, 1, -1, 1, -1, -1, 1, "b2b_add_exec");
        push(RWB, E_RGW, -1, 1, -1, -1, -1, 0, -1, -1, "b2b_add_wb");
        push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "b2b_fetch");
        drain("b2b_add");
        OP = 6'h02; Funct = 6'h00;
        push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "b2b_fetch");
        push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "b2b_fetch");
        push(FWB, E_IRW | E_PCW, -1, -1, 0, -1, 0, -1, 0, 1, "b2b_fetch_wb");
        push(DEC, E_AW | E_BW | E_AOW, -1, -1, 0, -1, 2, -1, -1, 1, "b2b_decode");
        push(JMP, E_PCW, -1, -1, -1, -1, -1, -1, 2, -1, "b2b_jump");
        push(FET, E_MRD, 0, -1, -1, -1, -1, -1, -1, -1, "b2b_refetch");
        drain("b2b_jump");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_add;
        test_alu_funct;
        test_lw_wait3;
        test_sw;
        test_branch;
        test_lui_jump_nop;
        test_undefined;
        test_overflow;
        test_break;
        test_reset_mid_memwr;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Parametrised multicycle control unit for the MIPS-subset processor datapath. A Moore FSM decodes `OP`/`Funct` and drives every datapath enable and mux select. It supports memory with a configurable number of wait cycles. Undefined instructions, and optionally arithmetic overflow, are handled as precise exceptions through EPC/Cause.

## Interface
Parameters:
- `MEM_WAIT`, default 1: cycles a memory read/write is held (legal 1..7).
- `CNT_W`, default 3: width of the wait counter; must satisfy `2**CNT_W > MEM_WAIT`.

Ports:
- `clk` in 1: single clock; all state changes on posedge.
- `Reset` in 1: synchronous, active-high.
- `OP` in 6: IR[31:26].
- `Funct` in 6: IR[5:0].
- `Zero` in 1: ALU zero flag, same cycle.
- `Overflow` in 1: ALU overflow flag, same cycle.
- `PCWrite`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA`, `AWrite`, `BWrite`, `ALUOutWrite`, `EPCWrite`, `CauseWrite`, `IntCause` out 1 each: datapath controls.
- `ALUSrcB` out 2: 00=4, 01=B, 10=SE<<2, 11=SE.
- `MemtoReg` out 2: 00=ALUOut, 01=MDR, 10=imm<<16.
- `PCSource` out 2: 00=ALU, 01=ALUOut, 10=jump target, 11=exception vector.
- `ALUOp` out 3: 0 LOAD, 1 ADD, 2 SUB, 3 AND, 4 INC, 5 NOT, 6 XOR, 7 CMP.
- `State` out 6: current state code, for debug.
- `Halted` out 1: high in BREAK.

## Operation
- States: RESET(0), FETCH, FETCH_WB, DECODE, EXEC_R, R_WB, BRANCH, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, LUI_WB, JUMP, BREAK, EXC_EPC, EXC_JUMP.
- RESET: all outputs 0 -> FETCH.
- FETCH:
  - `MemRead`=1, `IorD`=0.
  - Held `MEM_WAIT` cycles via the wait counter -> FETCH_WB.
- FETCH_WB:
  - `IRWrite`=1; `PCWrite`=1, `PCSource`=00, `ALUSrcA`=0, `ALUSrcB`=00, ADD.
  - -> DECODE.
- DECODE:
  - `AWrite`=`BWrite`=`ALUOutWrite`=1; `ALUSrcA`=0, `ALUSrcB`=10, ADD (branch target).
  - Dispatch on OP:
    - 0x00 -> EXEC_R; Funct 0x0D -> BREAK; Funct 0x00 (NOP) -> FETCH.
    - 0x04/0x05 -> BRANCH.
    - 0x23/0x2B -> MEM_ADDR.
    - 0x0F -> LUI_WB.
    - 0x02 -> JUMP.
    - anything else, including unknown Funct -> EXC_EPC with cause 0.
- EXEC_R:
  - `ALUSrcA`=1, `ALUSrcB`=01, `ALUOutWrite`=1.
  - `ALUOp` from Funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x26 XOR.
  - -> R_WB.
- R_WB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=00 -> FETCH.
- BRANCH:
  - `ALUSrcA`=1, `ALUSrcB`=01, SUB, `PCSource`=01.
  - `PCWrite` = `Zero` for BEQ, `!Zero` for BNE; this is the only Mealy output.
  - -> FETCH.
- MEM_ADDR: `ALUSrcA`=1, `ALUSrcB`=11, ADD, `ALUOutWrite`=1 -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: `MemRead`=1, `IorD`=1, `MEM_WAIT` cycles -> MEM_WB.
- MEM_WB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=01 -> FETCH.
- MEM_WR: `MemWrite`=1, `IorD`=1, `MEM_WAIT` cycles -> FETCH.
- LUI_WB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=10 -> FETCH.
- JUMP: `PCWrite`=1, `PCSource`=10 -> FETCH.
- BREAK: `Halted`=1, all enables 0; stays until `Reset`.
- EXC_EPC:
  - `ALUSrcA`=0, `ALUSrcB`=00, SUB (EPC = PC-4).
  - `EPCWrite`=1, `CauseWrite`=1, `IntCause` = latched cause.
  - -> EXC_JUMP.
- EXC_JUMP: `PCWrite`=1, `PCSource`=11 -> FETCH.

## Timing
- Reset:
  - At a posedge with `Reset`=1: state <= RESET, wait counter <= 0, cause <= 0.
  - While `Reset` is high, every write/enable output is forced 0 combinationally, including mid-instruction, so no partial write occurs.
  - `State` reads 0 on the first cycle after reset.
- Latencies (W = `MEM_WAIT`): R-type W+4, LW 2W+4, SW 2W+3, BEQ/BNE/LUI/J W+3, exception path W+4.
- Wait counter:
  - Reloads to 0 on entry to FETCH, MEM_RD or MEM_WR.
  - Leaves the state when count = `MEM_WAIT`-1.
  - Memory inputs are held stable throughout the wait.
- Simultaneous events:
  - `Overflow` in EXEC_R takes priority over R_WB; rd is never written.
  - Overflow is ignored outside EXEC_R and for AND/XOR.

## Configuration
- `CTRL_OVF_EXC_EN` defined: ADD/SUB with `Overflow`=1 in EXEC_R -> EXC_EPC with cause 1.
- `CTRL_OVF_EXC_EN` undefined:
  - `Overflow` is unused; EXEC_R always -> R_WB and the wrapped result is written.
  - Cause 1 is never produced.

## Structure
- `ctrl_pkg` holds:
  - the state enum (6-bit);
  - opcode and Funct constants;
  - ALUOp, ALUSrcB, PCSource and MemtoReg encodings;
  - cause codes.
- Sub-module `ctrl_wait_cnt`:
  - `CNT_W`-bit up counter with `clear` and `done` outputs.
  - One instance, shared by FETCH, MEM_RD and MEM_WR.

## Test plan
- `ADD` (OP 0, Funct 0x20), `MEM_WAIT`=1: `RegWrite`=1 exactly in cycle 5, `RegDst`=1; `State` returns to FETCH in cycle 6.
- `LW` (OP 0x23) with `MEM_WAIT`=3: `MemRead` held 3 cycles in MEM_RD with `IorD`=1; `RegWrite` with `MemtoReg`=01 in cycle 10.
- `BNE` (OP 0x05): `Zero`=1 gives no `PCWrite` in BRANCH; `Zero`=0 gives `PCWrite`=1 with `PCSource`=01.
- OP 0x3F: EXC_EPC shows `EPCWrite`=1, `CauseWrite`=1, `IntCause`=0, ALUOp SUB; then EXC_JUMP shows `PCSource`=11.
- With `CTRL_OVF_EXC_EN` set, `SUB` with `Overflow`=1: `RegWrite` never asserted, `IntCause`=1. Without the macro: R_WB is reached.
- `Reset` asserted during MEM_WR: `MemWrite` drops to 0 the same cycle and `State`=0 next cycle. `BREAK` (Funct 0x0D): `Halted`=1 is held until reset.
